// File: rtl/idea_ctrl.sv
// Sequencer for an iterated IDEA datapath: steps a shared external round unit
// through 8 rounds plus the output transform, one step per clock.
module idea_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         action,
    input  logic         abort,
    input  logic [0:63]  text,
    input  logic [0:895] keysList,
    input  logic [0:895] keysListInv,
    input  logic [0:63]  roundOut,
    output logic [0:63]  roundIn,
    output logic [0:127] roundKey,
    output logic         roundMode,
    output logic         busy,
    output logic         done,
    output logic [0:63]  encryptedText
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t       state;
    logic [3:0]   stepCnt;
    logic         actSel;
    logic [0:63]  dataReg;
    logic [0:895] keys;
    logic [3:0]   win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            stepCnt       <= 4'd0;
            actSel        <= 1'b0;
            dataReg       <= '0;
            encryptedText <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dataReg <= text;
                        actSel  <= action;
                        stepCnt <= 4'd0;
                        state   <= RUN;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= IDLE;
                        stepCnt <= 4'd0;
                        busy    <= 1'b0;
                    end else begin
                        dataReg <= roundOut;
                        if (stepCnt >= 4'd8) begin
                            // Last step is the output transform; counter parks at 0.
                            encryptedText <= roundOut;
                            stepCnt       <= 4'd0;
                            state         <= DONE;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                        end else begin
                            stepCnt <= stepCnt + 4'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    stepCnt <= 4'd0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    assign roundIn   = dataReg;
    assign keys      = actSel ? keysList : keysListInv;
    assign win       = (state == RUN) ? stepCnt : 4'd0;
    assign roundMode = !((state == RUN) && (stepCnt >= 4'd7));

    // Subkey windows advance by six 16-bit keys per step, eight keys wide.
    always_comb begin
        roundKey = keys[0:127];
        for (int i = 1; i < 9; i++) begin
            if (win == 4'(i)) roundKey = keys[96*i +: 128];
        end
    end

endmodule

// File: tb/tb_idea_ctrl.sv
// Bench for idea_ctrl: an IDEA round model drives roundOut, directed
// scenarios check timing, key windows, abort and reset behaviour.
module tb_idea_ctrl;

    localparam logic [0:63] PT = 64'h0000_0001_0002_0003;
    localparam logic [0:63] CT = 64'h11FB_ED2B_0198_6DE5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         action = 1'b0;
    logic         abort = 1'b0;
    logic [0:63]  text = '0;
    logic [0:895] keysList = '0;
    logic [0:895] keysListInv = '0;
    logic [0:63]  roundOut;
    logic [0:63]  roundIn;
    logic [0:127] roundKey;
    logic         roundMode;
    logic         busy;
    logic         done;
    logic [0:63]  encryptedText;
    logic         prev_mode = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    idea_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .action(action), .abort(abort),
        .text(text), .keysList(keysList), .keysListInv(keysListInv),
        .roundOut(roundOut), .roundIn(roundIn), .roundKey(roundKey),
        .roundMode(roundMode), .busy(busy), .done(done), .encryptedText(encryptedText)
    );

    function automatic logic [15:0] mmul(input logic [15:0] a, input logic [15:0] b);
        longint x, y, p;
        x = (a == 16'd0) ? 65536 : longint'(a);
        y = (b == 16'd0) ? 65536 : longint'(b);
        p = (x * y) % 65537;
        return (p == 65536) ? 16'd0 : 16'(p);
    endfunction

    function automatic logic [15:0] minv(input logic [15:0] a);
        logic [15:0] r, b;
        int e;
        r = 16'd1; b = a; e = 65535;
        while (e > 0) begin
            if (e % 2 == 1) r = mmul(r, b);
            b = mmul(b, b);
            e = e / 2;
        end
        return r;
    endfunction

    // Mode 1: full round with swap; mode 0: unswapped round, or the output
    // transform when the previous step was also mode 0.
    function automatic logic [0:63] idea_step(input logic [0:63] x, input logic [0:127] k,
                                              input logic mode, input logic last);
        logic [15:0] y1, y2, y3, y4, t0, t1, t2, t3, t4, t5;
        y1 = mmul(x[0:15], k[0:15]);
        y2 = x[16:31] + k[16:31];
        y3 = x[32:47] + k[32:47];
        y4 = mmul(x[48:63], k[48:63]);
        if (last) return {y1, y2, y3, y4};
        t0 = y1 ^ y3;
        t1 = y2 ^ y4;
        t2 = mmul(t0, k[64:79]);
        t3 = t1 + t2;
        t4 = mmul(t3, k[80:95]);
        t5 = t2 + t4;
        if (mode) return {y1 ^ t4, y3 ^ t4, y2 ^ t5, y4 ^ t5};
        return {y1 ^ t4, y2 ^ t5, y3 ^ t4, y4 ^ t5};
    endfunction

    always @(posedge clk) prev_mode <= roundMode;
    always_comb roundOut = idea_step(roundIn, roundKey, roundMode, !roundMode && !prev_mode);

    task automatic build_keys(input logic [127:0] key);
        logic [15:0]  z  [0:51];
        logic [15:0]  dz [0:51];
        logic [127:0] k;
        int b;
        k = key;
        for (int i = 0; i < 52; i++) begin
            if (i > 0 && i % 8 == 0) k = {k[102:0], k[127:103]};
            z[i] = k[127-16*(i%8) -: 16];
        end
        dz[0] = minv(z[48]); dz[1] = -z[49]; dz[2] = -z[50]; dz[3] = minv(z[51]);
        dz[4] = z[46];       dz[5] = z[47];
        for (int r = 1; r < 8; r++) begin
            b = 6 * (8 - r);
            dz[6*r]   = minv(z[b]);
            dz[6*r+1] = -z[b+2];
            dz[6*r+2] = -z[b+1];
            dz[6*r+3] = minv(z[b+3]);
            dz[6*r+4] = z[6*(7-r)+4];
            dz[6*r+5] = z[6*(7-r)+5];
        end
        dz[48] = minv(z[0]); dz[49] = -z[1]; dz[50] = -z[2]; dz[51] = minv(z[3]);
        keysList = '0;
        keysListInv = '0;
        for (int i = 0; i < 52; i++) begin
            keysList[16*i +: 16]    = z[i];
            keysListInv[16*i +: 16] = dz[i];
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #2;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (encryptedText !== 64'h0) begin n_bad++; $display("FAIL reset_out: got %h want 0", encryptedText); end
        n_cmp++; if (roundIn !== 64'h0) begin n_bad++; $display("FAIL reset_roundIn: got %h want 0", roundIn); end
        n_cmp++; if (roundMode !== 1'b1) begin n_bad++; $display("FAIL reset_mode: got %b want 1", roundMode); end
        n_cmp++; if (roundKey !== keysListInv[0:127]) begin n_bad++; $display("FAIL reset_key: got %h want %h", roundKey, keysListInv[0:127]); end
        start = 1'b1;
        tick;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_start_held: got %b want 0", busy); end
        start = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_encrypt;
        start = 1'b1; action = 1'b1; text = PT;
        tick;
        start = 1'b0; action = 1'b0; text = 64'hDEAD_BEEF_0BAD_F00D;
        n_cmp++; if (roundIn !== PT) begin n_bad++; $display("FAIL enc_load: got %h want %h", roundIn, PT); end
        for (int s = 0; s < 9; s++) begin
            n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL enc_busy step %0d: got busy=%b done=%b want 1/0", s, busy, done); end
            n_cmp++; if (roundKey !== keysList[96*s +: 128]) begin n_bad++; $display("FAIL enc_key step %0d: got %h want %h", s, roundKey, keysList[96*s +: 128]); end
            n_cmp++; if (roundMode !== (s < 7)) begin n_bad++; $display("FAIL enc_mode step %0d: got %b want %b", s, roundMode, s < 7); end
            n_cmp++; if (encryptedText !== 64'h0) begin n_bad++; $display("FAIL enc_hold step %0d: got %h want 0", s, encryptedText); end
            tick;
        end
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL enc_done: got done=%b busy=%b want 1/0", done, busy); end
        n_cmp++; if (encryptedText !== CT) begin n_bad++; $display("FAIL enc_result: got %h want %h", encryptedText, CT); end
        tick;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL enc_pulse: got %b want 0", done); end
    endtask

    task automatic test_decrypt;
        start = 1'b1; action = 1'b0; text = CT;
        tick;
        start = 1'b0; action = 1'b1; text = '0;
        for (int s = 0; s < 9; s++) begin
            n_cmp++; if (roundKey !== keysListInv[96*s +: 128]) begin n_bad++; $display("FAIL dec_key step %0d: got %h want %h", s, roundKey, keysListInv[96*s +: 128]); end
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL dec_early step %0d: got %b want 0", s, done); end
            tick;
        end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL dec_done: got %b want 1", done); end
        n_cmp++; if (encryptedText !== PT) begin n_bad++; $display("FAIL dec_result: got %h want %h", encryptedText, PT); end
        tick;
    endtask

    task automatic test_back_to_back;
        int m;
        start = 1'b1; action = 1'b1; text = PT;
        for (int c = 1; c <= 33; c++) begin
            tick;
            m = c % 11;
            n_cmp++; if (done !== (m == 10)) begin n_bad++; $display("FAIL b2b_done cycle %0d: got %b want %b", c, done, m == 10); end
            n_cmp++; if (busy !== (m >= 1 && m <= 9)) begin n_bad++; $display("FAIL b2b_busy cycle %0d: got %b want %b", c, busy, m >= 1 && m <= 9); end
            if (m == 10) begin
                n_cmp++; if (encryptedText !== CT) begin n_bad++; $display("FAIL b2b_result cycle %0d: got %h want %h", c, encryptedText, CT); end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_abort;
        start = 1'b1; action = 1'b0; text = CT;
        tick;
        start = 1'b0;
        repeat (4) tick;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_pre: got %b want 1", busy); end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got busy=%b done=%b want 0/0", busy, done); end
        for (int c = 0; c < 12; c++) begin
            n_cmp++; if (done !== 1'b0 || encryptedText !== CT) begin n_bad++; $display("FAIL abort_quiet cycle %0d: got done=%b out=%h want 0/%h", c, done, encryptedText, CT); end
            tick;
        end
        start = 1'b1; abort = 1'b1; action = 1'b0; text = CT;
        tick;
        start = 1'b0; abort = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_with_start: got %b want 1", busy); end
        repeat (9) tick;
        n_cmp++; if (done !== 1'b1 || encryptedText !== PT) begin n_bad++; $display("FAIL abort_restart: got done=%b out=%h want 1/%h", done, encryptedText, PT); end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || encryptedText !== PT) begin n_bad++; $display("FAIL abort_in_done: got done=%b busy=%b out=%h want 0/0/%h", done, busy, encryptedText, PT); end
    endtask

    task automatic test_reset_mid_run;
        start = 1'b1; action = 1'b1; text = PT;
        tick;
        start = 1'b0;
        repeat (5) tick;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_flags: got busy=%b done=%b want 0/0", busy, done); end
        n_cmp++; if (encryptedText !== 64'h0 || roundIn !== 64'h0) begin n_bad++; $display("FAIL rst_mid_regs: got out=%h in=%h want 0/0", encryptedText, roundIn); end
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; action = 1'b1; text = PT;
        tick;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_first_edge: got %b want 1", busy); end
        repeat (9) tick;
        n_cmp++; if (done !== 1'b1 || encryptedText !== CT) begin n_bad++; $display("FAIL rst_rerun: got done=%b out=%h want 1/%h", done, encryptedText, CT); end
        tick;
    endtask

    initial begin
        build_keys(128'h0001_0002_0003_0004_0005_0006_0007_0008);
        test_reset;
        test_encrypt;
        test_decrypt;
        test_back_to_back;
        test_abort;
        test_reset_mid_run;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/idea_ctrl.md
IDEA_CTRL -- requirements
Module: idea_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Ports are listed below as name, direction, width, meaning.
REQ-002 clk  in  1  Single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  Asynchronous, active-low reset.
REQ-004 start  in  1  Request to process one 64-bit block.
REQ-005 action  in  1  Operation select, sampled with start: 1 = encrypt, 0 = decrypt.
REQ-006 abort  in  1  Synchronous cancel of the operation in progress.
REQ-007 text  in  64 [0:63]  Input block, sampled with start.
REQ-008 keysList  in  896 [0:895]  Encryption subkey schedule.
REQ-009 keysListInv  in  896 [0:895]  Decryption subkey schedule.
REQ-010 roundOut  in  64 [0:63]  Combinational result from the shared round unit.
REQ-011 roundIn  out  64 [0:63]  Data presented to the round unit.
REQ-012 roundKey  out  128 [0:127]  Subkey window presented to the round unit.
REQ-013 roundMode  out  1  Round-type flag to the round unit.
REQ-014 busy  out  1  High while an operation is in progress.
REQ-015 done  out  1  One-cycle pulse marking a valid result.
REQ-016 encryptedText  out  64 [0:63]  Result register.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 In IDLE, when start is 1 at an edge, the block SHALL load dataReg<=text, latch actSel<=action, clear stepCnt<=0 and go to RUN.
REQ-019 start SHALL be ignored in RUN and DONE, with no queuing and no effect.
REQ-020 In RUN, each edge SHALL perform dataReg<=roundOut and stepCnt<=stepCnt+1.
  - stepCnt is 4 bits and counts steps 0..8.
REQ-021 At the RUN edge where stepCnt==8, the block SHALL:
  - load encryptedText<=roundOut;
  - go to DONE.
REQ-022 DONE SHALL last exactly one cycle, then the FSM SHALL return to IDLE.
REQ-023 Latency: start accepted at edge E0 SHALL give done=1 in the cycle after edge E0+9, i.e. 10 cycles from acceptance.
REQ-024 A start in the cycle done=1 SHALL be ignored; the earliest next acceptance is the following cycle.
  - Peak throughput is one block per 11 cycles.
REQ-025 Output decodes:
  - roundIn SHALL equal dataReg combinationally.
  - busy SHALL be 1 exactly in RUN.
  - done SHALL be 1 exactly in DONE.
REQ-026 roundKey SHALL be keys[96*stepCnt : 96*stepCnt+127].
  - keys = keysList when actSel==1, else keysListInv.
  - Window start bits: step 0 at bit 0, step 8 at bit 768, ending at bit 895.
REQ-027 roundMode SHALL be 1 for stepCnt 0..6 and 0 for stepCnt 7 and 8.
REQ-028 In IDLE and DONE, roundKey SHALL present step-0 window and roundMode SHALL be 1; the round unit's output is unused in these states.
REQ-029 encryptedText SHALL change only at the stepCnt==8 edge and SHALL hold its value otherwise, including across later start/abort.
REQ-030 Changes to action, text, keysList or keysListInv after acceptance SHALL NOT affect the operation in progress.
  - Exception: the key schedules are read live and SHALL be held stable by the integrator while busy=1.
REQ-031 abort=1 at an edge in RUN SHALL:
  - force IDLE and clear stepCnt;
  - produce no done pulse;
  - leave encryptedText unchanged.
REQ-032 abort=1 in IDLE or DONE SHALL have no effect; the DONE pulse still completes.
REQ-033 start and abort together in IDLE SHALL accept start; abort applies only in RUN.
REQ-034 stepCnt SHALL never exceed 8; an unreachable FSM encoding SHALL recover to IDLE on the next edge.

Reset
REQ-035 rst_n=0 SHALL immediately, without waiting for clk, set:
  - state IDLE;
  - stepCnt=0, actSel=0, dataReg=0, encryptedText=0;
  - busy=0, done=0.
REQ-036 Reset asserted mid-RUN SHALL abandon the operation with no done pulse.
REQ-037 The first edge after rst_n rises SHALL be able to accept start.

Verification
REQ-038 Encrypt vector:
  - Stimulus: key 0001000200030004000500060007 0008, text 0000000100020003, action=1, start pulse.
  - Required: busy for 9 cycles, then done=1 for one cycle with encryptedText=11FBED2B01986DE5.
REQ-039 Decrypt vector:
  - Stimulus: same key, text 11FBED2B01986DE5, action=0.
  - Required: encryptedText=0000000100020003 after 10 cycles.
REQ-040 Key window and mode sequence:
  - Stimulus: run one operation and monitor each RUN cycle.
  - Required: roundKey start bit = 0,96,...,768 and roundMode = 1,1,1,1,1,1,1,0,0.
REQ-041 Start during busy or done:
  - Stimulus: start held high continuously.
  - Required: acceptances exactly 11 cycles apart; every done separated by 10 busy/idle cycles.
REQ-042 Abort:
  - Stimulus: abort at RUN step 4.
  - Required: IDLE next cycle, no done, encryptedText keeps its prior value; a new start completes normally.
REQ-043 Reset mid-run:
  - Stimulus: rst_n low asynchronously at step 5.
  - Required: busy=0, done=0, encryptedText=0 before the next clk edge.
